// File: rtl/branch_resolve_unit.sv
// Resolution-side partner of the 2-bit branch predictor: queues fetch-time
// predictions, pairs them in order with execute outcomes, drives updates and flushes.
module branch_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pred_valid,
   input  logic                     pred_taken,
   output logic                     pred_ready,
   input  logic                     res_valid,
   input  logic                     res_taken,
   output logic                     res_ready,
   output logic                     upd_valid,
   output logic                     upd_taken,
   output logic                     mispredict,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_W-1:0]         branch_count,
   output logic [CNT_W-1:0]         mispredict_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]      PTR_ZERO = {(AW+1){1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FULL   = 2'd2,
      ST_FLUSH  = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [AW:0]      wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
   logic             mem_r [DEPTH];
   logic             push_s, pop_s, miss_s;
   logic             next_full_s, next_empty_s;
   logic             upd_valid_r, upd_taken_r, mispredict_r;
   logic [CNT_W-1:0] branch_cnt_r, miss_cnt_r;

   assign pred_ready = (state_r == ST_EMPTY) || (state_r == ST_ACTIVE);
   assign res_ready  = (state_r == ST_ACTIVE) || (state_r == ST_FULL);
   assign push_s     = pred_valid && pred_ready;
   assign pop_s      = res_valid && res_ready;
   assign miss_s     = pop_s && (mem_r[rd_ptr_r[AW-1:0]] != res_taken);

   // Next pointers; a mispredict collapses the queue onto the slot after the popped entry.
   always_comb begin
      wr_ptr_s = wr_ptr_r;
      rd_ptr_s = rd_ptr_r;
      if (miss_s) begin
         rd_ptr_s = rd_ptr_r + PTR_ONE;
         wr_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
         if (push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_s = rd_ptr_r;
         end
      end
   end

   assign next_full_s  = (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]) && (wr_ptr_s[AW] != rd_ptr_s[AW]);
   assign next_empty_s = (wr_ptr_s == rd_ptr_s);

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (push_s) begin
               state_s = ST_ACTIVE;
            end else begin
               state_s = ST_EMPTY;
            end
         end
         ST_ACTIVE: begin
            if (miss_s) begin
               state_s = ST_FLUSH;
            end else if (next_full_s) begin
               state_s = ST_FULL;
            end else if (next_empty_s) begin
               state_s = ST_EMPTY;
            end else begin
               state_s = ST_ACTIVE;
            end
         end
         ST_FULL: begin
            if (miss_s) begin
               state_s = ST_FLUSH;
            end else if (pop_s) begin
               state_s = ST_ACTIVE;
            end else begin
               state_s = ST_FULL;
            end
         end
         ST_FLUSH: state_s = ST_EMPTY;
         default:  state_s = ST_EMPTY;
      endcase
   end

   // Prediction storage; stale contents are never read because pops require an occupied slot.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= pred_taken;
      end
   end

   // State, pointers, update strobes and saturating statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_EMPTY;
         wr_ptr_r     <= PTR_ZERO;
         rd_ptr_r     <= PTR_ZERO;
         upd_valid_r  <= 1'b0;
         upd_taken_r  <= 1'b0;
         mispredict_r <= 1'b0;
         branch_cnt_r <= CNT_ZERO;
         miss_cnt_r   <= CNT_ZERO;
      end else begin
         state_r      <= state_s;
         wr_ptr_r     <= wr_ptr_s;
         rd_ptr_r     <= rd_ptr_s;
         upd_valid_r  <= pop_s;
         mispredict_r <= miss_s;
         if (pop_s) begin
            upd_taken_r <= res_taken;
         end
         if (pop_s && (branch_cnt_r != CNT_MAX)) begin
            branch_cnt_r <= branch_cnt_r + CNT_ONE;
         end
         if (miss_s && (miss_cnt_r != CNT_MAX)) begin
            miss_cnt_r <= miss_cnt_r + CNT_ONE;
         end
      end
   end

   assign occupancy        = wr_ptr_r - rd_ptr_r;
   assign upd_valid        = upd_valid_r;
   assign upd_taken        = upd_taken_r;
   assign mispredict       = mispredict_r;
   assign branch_count     = branch_cnt_r;
   assign mispredict_count = miss_cnt_r;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution-side partner of the 2-bit branch predictor `state_machine`.
- Queues each prediction issued at fetch. Pairs it, in program order, with the actual outcome reported at execute.
- Drives the predictor's `taken` update input, flags mispredictions, flushes wrong-path predictions, and keeps branch and mispredict statistics.

Parameters:
- DEPTH, 4, prediction queue entries; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- pred_valid  input  1  a prediction is offered this cycle.
- pred_taken  input  1  predicted direction (predictor `predict` output).
- pred_ready  output  1  queue accepts a prediction; combinational from state.
- res_valid  input  1  oldest outstanding branch resolved this cycle.
- res_taken  input  1  actual branch outcome.
- res_ready  output  1  a resolution can be accepted; combinational from state.
- upd_valid  output  1  registered; predictor update strobe.
- upd_taken  output  1  registered; actual outcome, feeds predictor `taken`.
- mispredict  output  1  registered; one-cycle pulse on wrong prediction.
- occupancy  output  $clog2(DEPTH)+1  entries currently queued.
- branch_count  output  CNT_W  resolved branches; saturating.
- mispredict_count  output  CNT_W  mispredicted branches; saturating.

Behaviour:
- Reset values:
  - State is EMPTY.
  - Queue pointers, occupancy, upd_valid, upd_taken, mispredict, branch_count and mispredict_count are all 0.
  - Reset asserted mid-operation discards every queued entry at that edge.
- Push: on pred_valid && pred_ready, pred_taken is written at the write pointer. The write pointer advances modulo DEPTH.
- Pop: on res_valid && res_ready, the entry at the read pointer is compared with res_taken. The read pointer advances modulo DEPTH.
- Pointers carry one extra wrap bit. Full when the index bits are equal and the wrap bits differ; empty when both are equal.
- pred_ready = state is EMPTY or ACTIVE.
- res_ready = state is ACTIVE or FULL.
- Inputs offered while not ready are ignored and produce no side effects.
- Update output, one cycle after every pop:
  - upd_valid = 1 for one cycle.
  - upd_taken = res_taken.
  - branch_count increments, holding at 2^CNT_W-1.
- Mispredict, when the popped entry != res_taken:
  - Next cycle: mispredict = 1 and mispredict_count increments (saturating).
  - Same edge as the pop: every remaining entry is flushed (pointers equalized, occupancy = 0).
  - A push accepted in the same cycle is also discarded as wrong-path.
- Simultaneous push and pop with a correct prediction: occupancy is unchanged and both operations complete.
- States:
  - EMPTY: occupancy 0.
  - ACTIVE: 0 < occupancy < DEPTH.
  - FULL: occupancy == DEPTH.
  - FLUSH: one-cycle redirect bubble. pred_ready = 0 and res_ready = 0.
- Transitions:
  - EMPTY -> ACTIVE on push.
  - ACTIVE -> FULL on a push without a pop that reaches DEPTH.
  - ACTIVE -> EMPTY on a correct pop without a push that reaches 0.
  - FULL -> ACTIVE on a correct pop.
  - ACTIVE or FULL -> FLUSH on a mispredicting pop.
  - FLUSH -> EMPTY unconditionally.
  - Otherwise the state holds.
- FULL with pred_valid and a correct pop in the same cycle: the push is not accepted, because pred_ready = 0.
- Latency:
  - Prediction to earliest resolution: 1 cycle.
  - Resolution to upd_valid and mispredict: 1 cycle.
  - Mispredict to next accepted push: 2 edges, covering the FLUSH cycle.
- Counter widths: CNT_W bits, saturating, never wrapping.

Test Plan:
1. Reset held 2 cycles, then released -> every output 0; pred_ready = 1 and res_ready = 0 in EMPTY.
2. Push predictions 1,0,1,1 (DEPTH=4) -> occupancy 1..4; state FULL; pred_ready = 0; a fifth push is ignored and occupancy stays 4.
3. From the FULL state of scenario 2, resolve 1,0,1,1 one per cycle ->
   - upd_valid pulses 4 times with upd_taken 1,0,1,1.
   - mispredict stays 0.
   - branch_count = 4, mispredict_count = 0, occupancy returns to 0.
4. Push 1,1,1, then resolve 0 ->
   - Next cycle: mispredict = 1, upd_taken = 0, occupancy = 0, state FLUSH with pred_ready = 0.
   - The cycle after: EMPTY; mispredict_count = 1, branch_count = 1.
5. Occupancy 2 with a simultaneous push 0 and correct pop -> occupancy stays 2; the pointers wrap past DEPTH-1 correctly over 6 such cycles.
6. Assert reset while FULL, mid-stream -> occupancy 0 and state EMPTY at the next edge; counters return to 0; res_valid in the following cycle produces no upd_valid.
